// File: rtl/counter_updown_param.sv
// Parameterised up/down counter with a runtime modulus, wrap or saturate at the bounds,
// and load/clear controls. It has a registered wrap pulse and a sticky saturation flag.
module counter_updown_param #(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned RESET_VALUE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     up_dn,
    input  logic                     sat_mode,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_value,
    input  logic [COUNTER_WIDTH-1:0] max_value,
    output logic [COUNTER_WIDTH-1:0] count_out,
    output logic                     tc,
    output logic                     wrap_pulse,
    output logic                     sat_hit
);

    localparam int unsigned W = COUNTER_WIDTH;
    localparam logic [W-1:0] RST_VAL = W'(RESET_VALUE);

    logic         at_top;
    logic         at_bot;
    logic [W-1:0] count_nxt;
    logic         wrap_nxt;
    logic         sat_nxt;

    assign at_top = (count_out >= max_value);
    assign at_bot = (count_out == '0);

    // Terminal count is combinational; it looks ahead at the step about to be taken.
    assign tc = en & ((up_dn & at_top) | (~up_dn & at_bot));

    // Next-state selection in priority order: clear, load, step, hold.
    always_comb begin
        count_nxt = count_out;
        wrap_nxt  = 1'b0;
        sat_nxt   = sat_hit;
        if (clear) begin
            count_nxt = RST_VAL;
            sat_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = (load_value > max_value) ? max_value : load_value;
        end else if (en) begin
            if (up_dn) begin
                if (!at_top) begin
                    count_nxt = count_out + W'(1);
                end else if (sat_mode) begin
                    count_nxt = max_value;
                    sat_nxt   = 1'b1;
                end else begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                // A value stranded above a shrunken bound snaps back onto the bound.
                if (count_out > max_value) begin
                    count_nxt = max_value;
                end else if (!at_bot) begin
                    count_nxt = count_out - W'(1);
                end else if (sat_mode) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = max_value;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out  <= RST_VAL;
            wrap_pulse <= 1'b0;
            sat_hit    <= 1'b0;
        end else begin
            count_out  <= count_nxt;
            wrap_pulse <= wrap_nxt;
            sat_hit    <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_counter_updown_param.sv
// Scoreboard bench for counter_updown_param: it drives the inputs on the falling edge and
// queues the expected state. A monitor compares each queued state after the rising edge.
module tb_counter_updown_param;

    logic       clk = 1'b0;
    logic       rst, clear, en, up_dn, sat_mode, load;
    logic [7:0] load_value, max_value;
    logic [7:0] count_out;
    logic       tc, wrap_pulse, sat_hit;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] cnt;
        logic       wrap;
        logic       sat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int m_cnt  = 0;
    bit m_wrap = 1'b0;
    bit m_sat  = 1'b0;

    counter_updown_param #(.COUNTER_WIDTH(8), .RESET_VALUE(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .en         (en),
        .up_dn      (up_dn),
        .sat_mode   (sat_mode),
        .load       (load),
        .load_value (load_value),
        .max_value  (max_value),
        .count_out  (count_out),
        .tc         (tc),
        .wrap_pulse (wrap_pulse),
        .sat_hit    (sat_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check tc, and queue the state expected after the edge.
    task automatic drive(input bit r, input bit c, input bit l, input bit e, input bit u,
                         input bit s, input int lv, input int mv);
        bit exp_tc;
        @(negedge clk);
        rst = r; clear = c; load = l; en = e; up_dn = u; sat_mode = s;
        load_value = 8'(lv);
        max_value  = 8'(mv);
        #1;
        exp_tc = e && ((u && m_cnt >= mv) || (!u && m_cnt == 0));
        check("tc", 32'(tc), 32'(exp_tc));
        m_wrap = 1'b0;
        if (r || c) begin
            m_cnt = 0;
            m_sat = 1'b0;
        end else if (l) begin
            m_cnt = (lv > mv) ? mv : lv;
        end else if (e && u) begin
            if (m_cnt < mv) m_cnt = m_cnt + 1;
            else if (s) begin m_cnt = mv; m_sat = 1'b1; end
            else begin m_cnt = 0; m_wrap = 1'b1; end
        end else if (e) begin
            if (m_cnt > mv) m_cnt = mv;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
            else if (s) m_sat = 1'b1;
            else begin m_cnt = mv; m_wrap = 1'b1; end
        end
        sb_q.push_back('{cnt: 8'(m_cnt), wrap: m_wrap, sat: m_sat});
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the queued expectation for each edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("count", 32'(count_out), 32'(mon_e.cnt));
            check("wrap", 32'(wrap_pulse), 32'(mon_e.wrap));
            check("sat", 32'(sat_hit), 32'(mon_e.sat));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mv_pick;
        rst = 1'b1; clear = 1'b0; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b0;
        load_value = '0; max_value = '0;

        // Reset state
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0, 9);
        settle();
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_wrap", 32'(wrap_pulse), 32'd0);
        check("rst_sat", 32'(sat_hit), 32'd0);

        // Wrap up through max_value = 9
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0, 9);
            if (i == 9) begin
                settle();
                check("wrap9_count", 32'(count_out), 32'd0);
                check("wrap9_pulse", 32'(wrap_pulse), 32'd1);
            end
        end

        // Saturating count-down from 3
        drive(0, 0, 1, 0, 1, 1, 3, 9);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 1, 0, 9);
        drive(0, 0, 0, 0, 0, 1, 0, 9);
        settle();
        check("satdn_count", 32'(count_out), 32'd0);
        check("satdn_sticky", 32'(sat_hit), 32'd1);
        drive(0, 1, 0, 0, 0, 1, 0, 9);

        // Priority among rst, clear, load, and en
        drive(0, 0, 1, 0, 1, 0, 5, 9);
        drive(1, 1, 1, 1, 1, 0, 5, 9);
        drive(0, 1, 1, 0, 1, 0, 5, 9);
        drive(0, 0, 1, 1, 1, 0, 7, 20);
        settle();
        check("prio_load7", 32'(count_out), 32'd7);

        // Load clamping and a shrinking max_value
        drive(0, 0, 1, 0, 1, 0, 200, 100);
        drive(0, 0, 0, 1, 1, 0, 0, 10);
        drive(0, 0, 1, 0, 1, 1, 200, 100);
        drive(0, 0, 0, 1, 1, 1, 0, 10);
        settle();
        check("shrink_sat_up", 32'(count_out), 32'd10);
        drive(0, 0, 1, 0, 1, 0, 100, 100);
        drive(0, 0, 0, 0, 0, 0, 0, 10);
        drive(0, 0, 0, 1, 0, 0, 0, 10);
        settle();
        check("shrink_dn", 32'(count_out), 32'd10);
        drive(0, 1, 0, 0, 1, 0, 0, 10);

        // Degenerate max_value = 0 in both directions and both modes
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, i[0], 1, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 0);

        // Reset asserted during the 255 -> 0 wrap
        drive(0, 0, 1, 0, 1, 0, 254, 255);
        drive(0, 0, 0, 1, 1, 0, 0, 255);
        drive(1, 0, 0, 1, 1, 0, 0, 255);
        settle();
        check("midrst_count", 32'(count_out), 32'd0);
        check("midrst_wrap", 32'(wrap_pulse), 32'd0);
        check("midrst_sat", 32'(sat_hit), 32'd0);

        // Random mix of all controls
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       mv_pick = 0;
                1:       mv_pick = 1;
                2:       mv_pick = 255;
                3:       mv_pick = 9;
                default: mv_pick = int'($urandom_range(0, 255));
            endcase
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  int'($urandom_range(0, 255)), mv_pick);
        end

        drive(0, 0, 0, 0, 1, 0, 0, 9);
        settle();
        @(posedge clk);
        #3;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
